// File: rtl/rgb_pwm_fader_pkg.sv
// Shared types, default constants and the level-to-duty mapping for the RGB
// PWM fader. Optional gamma mapping is enabled with RGB_PWM_FADER_GAMMA_EN.
package rgb_pwm_pkg;

  // Per-channel fade state
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } fade_state_t;

  // Default PWM / brightness resolution and clocks per one-LSB level step
  localparam int DEFAULT_PWM_BITS  = 8;
  localparam int DEFAULT_FADE_TICK = 3906;

  // Widest PWM resolution the mapping function supports
  localparam int MAX_PWM_BITS = 16;

  // Map a brightness level to a PWM duty value for a resolution of 'bits'.
  // Levels arrive zero-extended to MAX_PWM_BITS; the caller truncates the
  // result back to its own width.
  function automatic logic [MAX_PWM_BITS-1:0] level_to_duty(
    input logic [MAX_PWM_BITS-1:0] level,
    input int unsigned             bits
  );
    logic [MAX_PWM_BITS-1:0] maxLevel;
`ifdef RGB_PWM_FADER_GAMMA_EN
    logic [2*MAX_PWM_BITS-1:0] product;
`endif
    maxLevel = MAX_PWM_BITS'((32'd1 << bits) - 32'd1);
`ifdef RGB_PWM_FADER_GAMMA_EN
    // Square law: the upper half of the double-width product is the duty.
    // Full brightness is pinned to full duty so "on" is truly constant-high.
    product = (2*MAX_PWM_BITS)'(level) * (2*MAX_PWM_BITS)'(level);
    if (level == maxLevel) begin
      return maxLevel;
    end
    return MAX_PWM_BITS'(product >> bits);
`else
    // Linear mapping: duty equals level, no multiplier
    return level & maxLevel;
`endif
  endfunction

endpackage

// File: rtl/rgb_pwm_fader_channel.sv
// One colour channel of the RGB PWM fader: fade FSM, brightness level,
// period-aligned duty register and registered PWM output.
// Duty mapping follows RGB_PWM_FADER_GAMMA_EN through the package function.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = DEFAULT_PWM_BITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic                periodEnd_i,
  input  logic [PWM_BITS-1:0] pwmCnt_i,
  input  logic                target_i,
  output logic                pwm_o,
  output logic                atTarget_o
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

  fade_state_t         state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;

  // State, level, duty and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OFF;
      level_q <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  // Fade FSM: while ramping, the current target picks the step direction, so
  // a reversal on a tick cycle already steps the new way without a jump
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      OFF: begin
        level_d = '0;
        if (target_i) begin
          state_d = RISE;
        end
      end
      ON: begin
        level_d = LEVEL_MAX;
        if (!target_i) begin
          state_d = FALL;
        end
      end
      RISE, FALL: begin
        if (tick_i) begin
          if (target_i) begin
            if (level_q != LEVEL_MAX) begin
              level_d = level_q + 1'b1;
            end
          end else if (level_q != '0) begin
            level_d = level_q - 1'b1;
          end
        end
        if (target_i) begin
          state_d = (level_d == LEVEL_MAX) ? ON : RISE;
        end else begin
          state_d = (level_d == '0) ? OFF : FALL;
        end
      end
      default: begin
        state_d = OFF;
        level_d = '0;
      end
    endcase
  end

  // Duty only reloads at the end of a PWM period so a period is never split
  always_comb begin
    duty_d = duty_q;
    if (periodEnd_i) begin
      duty_d = PWM_BITS'(level_to_duty(MAX_PWM_BITS'(level_q), PWM_BITS));
    end
  end

  // Output compare; full duty is forced constant-high across the wrap cycle
  always_comb begin
    pwm_d = (duty_q == LEVEL_MAX) || (pwmCnt_i < duty_q);
  end

  // Channel is at rest only when idle in OFF/ON and the level matches target
  always_comb begin
    atTarget_o = 1'b0;
    if ((state_q == OFF) && (level_q == '0) && !target_i) begin
      atTarget_o = 1'b1;
    end
    if ((state_q == ON) && (level_q == LEVEL_MAX) && target_i) begin
      atTarget_o = 1'b1;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB PWM fader top: registers the on/off colour targets, generates the fade
// tick and the shared PWM counter, runs three fading channels and reports
// when all channels have settled. Gamma duty mapping: RGB_PWM_FADER_GAMMA_EN.
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS  = DEFAULT_PWM_BITS,
  parameter int FADE_TICK = DEFAULT_FADE_TICK
) (
  input  logic clk,
  input  logic rst,
  input  logic red_in,
  input  logic green_in,
  input  logic blue_in,
  output logic red_pwm,
  output logic green_pwm,
  output logic blue_pwm,
  output logic settled
);

  localparam int                  TICK_W    = (FADE_TICK > 1) ? $clog2(FADE_TICK) : 1;
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(FADE_TICK - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;

  // Target bits: [0] red, [1] green, [2] blue; 1 means full brightness
  logic [2:0]          target_q, target_d;
  logic [TICK_W-1:0]   tickCnt_q, tickCnt_d;
  logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
  logic                settled_q, settled_d;
  logic                tick;
  logic                periodEnd;
  logic [2:0]          atTarget;

  // Shared counters, captured targets and the settled flag
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q  <= '0;
      tickCnt_q <= '0;
      pwmCnt_q  <= '0;
      settled_q <= 1'b1;
    end else begin
      target_q  <= target_d;
      tickCnt_q <= tickCnt_d;
      pwmCnt_q  <= pwmCnt_d;
      settled_q <= settled_d;
    end
  end

  // Next-state for the counters, target capture and settled detection
  always_comb begin
    tick      = (tickCnt_q == TICK_LAST);
    periodEnd = (pwmCnt_q == PWM_LAST);
    tickCnt_d = tick ? '0 : tickCnt_q + TICK_W'(1);
    pwmCnt_d  = pwmCnt_q + PWM_BITS'(1);
    target_d  = {blue_in, green_in, red_in};
    settled_d = &atTarget;
  end

  pwm_channel #(
    .PWM_BITS(PWM_BITS)
  ) u_red (
    .clk_i      (clk),
    .rst_i      (rst),
    .tick_i     (tick),
    .periodEnd_i(periodEnd),
    .pwmCnt_i   (pwmCnt_q),
    .target_i   (target_q[0]),
    .pwm_o      (red_pwm),
    .atTarget_o (atTarget[0])
  );

  pwm_channel #(
    .PWM_BITS(PWM_BITS)
  ) u_green (
    .clk_i      (clk),
    .rst_i      (rst),
    .tick_i     (tick),
    .periodEnd_i(periodEnd),
    .pwmCnt_i   (pwmCnt_q),
    .target_i   (target_q[1]),
    .pwm_o      (green_pwm),
    .atTarget_o (atTarget[1])
  );

  pwm_channel #(
    .PWM_BITS(PWM_BITS)
  ) u_blue (
    .clk_i      (clk),
    .rst_i      (rst),
    .tick_i     (tick),
    .periodEnd_i(periodEnd),
    .pwmCnt_i   (pwmCnt_q),
    .target_i   (target_q[2]),
    .pwm_o      (blue_pwm),
    .atTarget_o (atTarget[2])
  );

  assign settled = settled_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Testbench for rgb_pwm_fader with PWM_BITS=4, FADE_TICK=4. A behavioural
// model predicts levels, settled and per-period PWM high counts; expected
// period counts are queued when the duty is latched and compared once the
// DUT has played the whole period. Honours RGB_PWM_FADER_GAMMA_EN.
module tb_rgb_pwm_fader;
  import rgb_pwm_pkg::*;

  localparam int PB     = 4;
  localparam int FT     = 4;
  localparam int MAXL   = 15;
  localparam int PERIOD = 16;

  logic clk = 1'b0;
  logic rst;
  logic redIn, greenIn, blueIn;
  logic red_pwm, green_pwm, blue_pwm, settled;

  int checks = 0;
  int errors = 0;

  // Model state
  int mTgt   [3];
  int mLevel [3];
  bit mFading[3];
  int mDuty  [3];
  int mTick;
  int mPwm;
  bit mSettled;

  typedef struct {
    int r;
    int g;
    int b;
  } expPeriod_t;
  expPeriod_t sbQ[$];

  int highAcc[3];
  bit windowOn;

  rgb_pwm_fader #(
    .PWM_BITS (PB),
    .FADE_TICK(FT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .red_in   (redIn),
    .green_in (greenIn),
    .blue_in  (blueIn),
    .red_pwm  (red_pwm),
    .green_pwm(green_pwm),
    .blue_pwm (blue_pwm),
    .settled  (settled)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Expected duty for a level, as seen by the perceptual mapping
  function automatic int expDuty(input int lvl);
`ifdef RGB_PWM_FADER_GAMMA_EN
    if (lvl == MAXL) return MAXL;
    return (lvl * lvl) / PERIOD;
`else
    return lvl;
`endif
  endfunction

  // Number of high cycles in one PWM period for a given duty
  function automatic int highCount(input int duty);
    return (duty == MAXL) ? PERIOD : duty;
  endfunction

  // Drive the three colour inputs and hold them for a number of cycles
  task automatic applyStimulus(input logic r, input logic g, input logic b, input int cycles);
    @(negedge clk);
    redIn   = r;
    greenIn = g;
    blueIn  = b;
    repeat (cycles) @(negedge clk);
  endtask

  // Behavioural model, advanced on every rising edge
  always @(posedge clk) begin : modelBlk
    int         tv;
    bit         tickNow;
    bit         allSet;
    expPeriod_t e;
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        mTgt[ch]    = 0;
        mLevel[ch]  = 0;
        mFading[ch] = 1'b0;
        mDuty[ch]   = 0;
      end
      mTick    = 0;
      mPwm     = 0;
      mSettled = 1'b1;
    end else begin
      tickNow = (mTick == FT - 1);
      allSet  = 1'b1;
      for (int ch = 0; ch < 3; ch++) begin
        tv = (mTgt[ch] != 0) ? MAXL : 0;
        if (mFading[ch] || (mLevel[ch] != tv)) allSet = 1'b0;
      end
      if (mPwm == MAXL) begin
        for (int ch = 0; ch < 3; ch++) mDuty[ch] = expDuty(mLevel[ch]);
        e.r = highCount(mDuty[0]);
        e.g = highCount(mDuty[1]);
        e.b = highCount(mDuty[2]);
        sbQ.push_back(e);
      end
      for (int ch = 0; ch < 3; ch++) begin
        tv = (mTgt[ch] != 0) ? MAXL : 0;
        if (mFading[ch]) begin
          if (tickNow) begin
            if (tv > mLevel[ch]) mLevel[ch] = mLevel[ch] + 1;
            else if (tv < mLevel[ch]) mLevel[ch] = mLevel[ch] - 1;
          end
          mFading[ch] = (mLevel[ch] != tv);
        end else begin
          mFading[ch] = (mLevel[ch] != tv);
        end
      end
      mSettled = allSet;
      mTick    = tickNow ? 0 : mTick + 1;
      mPwm     = (mPwm + 1) % PERIOD;
      mTgt[0]  = int'(redIn);
      mTgt[1]  = int'(greenIn);
      mTgt[2]  = int'(blueIn);
    end
  end

  // Monitor: per-cycle level/settled checks and per-period PWM scoreboard
  always @(negedge clk) begin : monBlk
    expPeriod_t e;
    if (rst) begin
      sbQ.delete();
      windowOn = 1'b0;
    end else begin
      checkOutput("settled", int'(settled), int'(mSettled));
      checkOutput("red_level", int'(dut.u_red.level_q), mLevel[0]);
      checkOutput("green_level", int'(dut.u_green.level_q), mLevel[1]);
      checkOutput("blue_level", int'(dut.u_blue.level_q), mLevel[2]);
      if ((mPwm == 1) && (sbQ.size() > 0)) begin
        windowOn = 1'b1;
        for (int ch = 0; ch < 3; ch++) highAcc[ch] = 0;
      end
      if (windowOn) begin
        highAcc[0] += int'(red_pwm);
        highAcc[1] += int'(green_pwm);
        highAcc[2] += int'(blue_pwm);
        if (mPwm == 0) begin
          e = sbQ.pop_front();
          checkOutput("red_period_high", highAcc[0], e.r);
          checkOutput("green_period_high", highAcc[1], e.g);
          checkOutput("blue_period_high", highAcc[2], e.b);
          windowOn = 1'b0;
        end
      end
    end
  end

  // Directed sequence followed by a short random run
  initial begin : stimBlk
    int  waited;
    int  onCount;
    rst     = 1'b1;
    redIn   = 1'b1;
    greenIn = 1'b1;
    blueIn  = 1'b1;

    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_red_pwm", int'(red_pwm), 0);
      checkOutput("rst_green_pwm", int'(green_pwm), 0);
      checkOutput("rst_blue_pwm", int'(blue_pwm), 0);
      checkOutput("rst_settled", int'(settled), 1);
      checkOutput("rst_red_level", int'(dut.u_red.level_q), 0);
    end

    rst     = 1'b0;
    redIn   = 1'b0;
    greenIn = 1'b0;
    blueIn  = 1'b0;
    repeat (10) @(negedge clk);

    // Red ramps fully on and stays constantly high
    applyStimulus(1'b1, 1'b0, 1'b0, 80);
    checkOutput("red_full_settled", int'(settled), 1);
    checkOutput("red_full_level", int'(dut.u_red.level_q), MAXL);
    onCount = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      onCount += int'(red_pwm);
    end
    checkOutput("red_full_const_high", onCount, PERIOD);

    // Cross-fade red down, green up
    applyStimulus(1'b0, 1'b1, 1'b0, 80);
    checkOutput("xfade_settled", int'(settled), 1);
    checkOutput("xfade_green_level", int'(dut.u_green.level_q), MAXL);
    checkOutput("xfade_red_level", int'(dut.u_red.level_q), 0);

    // Blue reversal at level 5
    applyStimulus(1'b0, 1'b1, 1'b1, 0);
    waited = 0;
    while ((mLevel[2] != 5) && (waited < 200)) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("blue_reach_5_timeout", int'(waited < 200), 1);
    blueIn = 1'b0;
    waited = 0;
    while ((int'(dut.u_blue.level_q) == 5) && (waited < 40)) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("blue_reversal_timeout", int'(waited < 40), 1);
    checkOutput("blue_reversal_level", int'(dut.u_blue.level_q), 4);
    checkOutput("blue_reversal_state", int'(dut.u_blue.state_q), int'(FALL));
    repeat (40) @(negedge clk);

    // Reset in the middle of a fade
    applyStimulus(1'b1, 1'b0, 1'b1, 30);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_red_level", int'(dut.u_red.level_q), 0);
    checkOutput("midrst_blue_level", int'(dut.u_blue.level_q), 0);
    checkOutput("midrst_green_level", int'(dut.u_green.level_q), 0);
    checkOutput("midrst_red_pwm", int'(red_pwm), 0);
    checkOutput("midrst_green_pwm", int'(green_pwm), 0);
    checkOutput("midrst_settled", int'(settled), 1);
    rst     = 1'b0;
    redIn   = 1'b0;
    greenIn = 1'b0;
    blueIn  = 1'b0;

    // Random colour changes of random duration
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(5, 70)));
    end

    // Drain to all-off
    applyStimulus(1'b0, 1'b0, 1'b0, 100);
    checkOutput("final_settled", int'(settled), 1);
    checkOutput("final_green_pwm", int'(green_pwm), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Sits directly downstream of the colour-cycling state machine.
- Consumes its three 1-bit on/off colour outputs and drives the RGB LED pins with PWM.
- Each channel ramps linearly between off and full brightness, so colour changes cross-fade instead of stepping.
- Reports when all channels have settled at their targets.

Parameters:
- PWM_BITS, 8, PWM and brightness-level resolution; MAX = 2^PWM_BITS-1.
- FADE_TICK, 3906, clk cycles per one-LSB level step. Full ramp = MAX*FADE_TICK (~83 ms at 12 MHz).

Ports:
- clk  input  1  system clock (12 MHz).
- rst  input  1  synchronous, active-high reset.
- red_in  input  1  red on/off target from the colour cycler.
- green_in  input  1  green on/off target.
- blue_in  input  1  blue on/off target.
- red_pwm  output  1  red LED drive, active-high.
- green_pwm  output  1  green LED drive, active-high.
- blue_pwm  output  1  blue LED drive, active-high.
- settled  output  1  high when every channel level equals its target.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. rst is sampled on posedge clk and overrides all other activity.
- Reset values:
  - target regs = 0, levels = 0, duties = 0, pwm_cnt = 0, tick_cnt = 0.
  - All *_pwm = 0.
  - settled = 1.
  - All channel FSMs = OFF.
- Input capture: *_in registered into target regs every cycle; target = MAX if bit=1, else 0. The FSM acts on the registered target one cycle later.
- Tick generator:
  - tick_cnt counts 0..FADE_TICK-1, then wraps to 0.
  - tick pulses for one cycle when tick_cnt == FADE_TICK-1.
- Per-channel FSM, states OFF, RISE, ON, FALL:
  - OFF: level=0; target=MAX -> RISE.
  - RISE: on tick, level += 1. Level reaching MAX -> ON. Target drops to 0 -> FALL; direction reverses from the current level at the next tick, with no jump.
  - ON: level=MAX; target=0 -> FALL.
  - FALL: on tick, level -= 1. Level reaching 0 -> OFF. Target goes to MAX -> RISE.
  - Level saturates: never wraps below 0 or above MAX.
- PWM:
  - pwm_cnt free-runs 0..MAX and wraps.
  - duty is reloaded from the level mapping only when pwm_cnt == MAX, so there is no mid-period glitch.
  - Output registered: pwm = 1 when pwm_cnt < duty.
  - Special case duty == MAX: output constant 1 (true full-on).
  - duty == 0: output constant 0.
- settled: registered; 1 iff all three FSMs are in OFF or ON and each level matches its target.
- Latency: input edge -> FSM state change in 2 cycles; first level step on the following tick; visible PWM change at the next PWM period boundary.
- Simultaneous events: tick and a target reversal in the same cycle -> the step uses the new direction.
- Reset mid-fade: all levels return to 0 immediately; outputs go low on the next cycle.

Optional Feature:
- Macro: RGB_PWM_FADER_GAMMA_EN.
- Defined: duty = (level*level) >> PWM_BITS, with level == MAX forced to duty MAX. Uses a 2*PWM_BITS-bit intermediate product and gives perceptually linear fades.
- Undefined: duty = level, with no multiplier inferred.

Decomposition:
- Package rgb_pwm_pkg holds:
  - typedef enum logic [1:0] fade_state_t {OFF, RISE, ON, FALL}.
  - Default PWM_BITS and FADE_TICK constants.
  - A level_to_duty function containing the gamma `ifdef.
- Sub-module pwm_channel holds one FSM, level, duty and output register. It is instantiated three times.
- Tick generator, pwm_cnt and settled logic live in the top level.

Test Plan (PWM_BITS=4, FADE_TICK=4):
- Reset held 3 cycles with all inputs 1 -> all *_pwm = 0, settled = 1, levels 0.
- red_in 0->1 -> red level reaches 15 after 60 cycles (15 ticks); red_pwm then constantly 1; settled returns to 1.
- red_in=1 fully on, then green_in 0->1 and red_in 1->0 together -> green duty rises while red duty falls in lockstep. At level 8, measured high-count is 8 of 16 cycles for each.
- Mid-RISE at level 5, target toggles to 0 -> next tick level = 4, FSM = FALL, no level jump.
- Change level during a PWM period -> duty changes only on the cycle after pwm_cnt == 15; no glitch pulse.
- With RGB_PWM_FADER_GAMMA_EN: level 8 -> duty 4 (4 of 16 high); level 15 -> constantly high. Without the macro: level 8 -> duty 8.
